// File: rtl/ceespu_console_pkg.sv
// Shared types and constants for the ceespu text console.
// CLEAR_SCREEN exists only when CEESPU_CONSOLE_CLS_EN is defined.
package ceespu_console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR_ROW
`ifdef CEESPU_CONSOLE_CLS_EN
    , CLEAR_SCREEN
`endif
  } console_state_t;

  localparam logic [7:0]  CHAR_CR    = 8'h0D;
  localparam logic [7:0]  CHAR_LF    = 8'h0A;
  localparam logic [7:0]  CHAR_BS    = 8'h08;
  localparam logic [7:0]  CHAR_FF    = 8'h0C;
  localparam logic [7:0]  CHAR_SPACE = 8'h20;
  localparam logic [31:0] BLANK_WORD = 32'h20202020;

  // Byte-lane strobe for a single byte write at the given address offset.
  function automatic logic [3:0] lane_strobe(input logic [1:0] byte_sel);
    return 4'b0001 << byte_sel;
  endfunction

endpackage

// File: rtl/ceespu_console_cursor.sv
// Column/row cursor for the text console, including end-of-line wrap and
// bottom-of-screen wrap on a line advance.
import ceespu_console_pkg::*;

module ceespu_console_cursor #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       back,
  input  logic       cr,
  input  logic       lf,
  input  logic       home,
  output logic [6:0] col,
  output logic [4:0] row,
  output logic       wrap_c,
  output logic [4:0] next_row_c
);

  assign wrap_c     = (col == 7'(COLS - 1));
  assign next_row_c = (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;

  // Commands are mutually exclusive; the top issues at most one per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= 7'd0;
      row <= 5'd0;
    end else if (home) begin
      col <= 7'd0;
      row <= 5'd0;
    end else if (step) begin
      if (wrap_c) begin
        col <= 7'd0;
        row <= next_row_c;
      end else begin
        col <= col + 7'd1;
      end
    end else if (back) begin
      col <= col - 7'd1;
    end else if (cr) begin
      col <= 7'd0;
    end else if (lf) begin
      row <= next_row_c;
    end
  end

endmodule

// File: rtl/ceespu_text_console.sv
// Byte-stream text console writing characters into a memory-mapped text RAM.
// Define CEESPU_CONSOLE_CLS_EN to make 0x0C (FF) clear the whole screen.
import ceespu_console_pkg::*;

module ceespu_text_console #(
  parameter logic [15:0] BASE_ADDR = 16'hF800,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 25
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_char_valid,
  input  logic [7:0]  I_char,
  output logic        O_char_ready,
  output logic [3:0]  O_sys_write_enable,
  output logic [15:0] O_sys_address,
  output logic [31:0] O_sys_data,
  output logic [6:0]  O_cursor_col,
  output logic [4:0]  O_cursor_row
);

  localparam int unsigned CLR_W     = 16;
  localparam int unsigned ROW_WORDS = COLS / 4;
`ifdef CEESPU_CONSOLE_CLS_EN
  localparam int unsigned SCREEN_WORDS = ROWS * COLS / 4;
`endif

  console_state_t   state;
  logic             wr_bs;
  logic [CLR_W-1:0] clr_cnt;

  logic [6:0]  col;
  logic [4:0]  row;
  logic        wrap_c;
  logic [4:0]  next_row_c;
  logic        accept_c;
  logic        printable_c;
  logic        step_c;
  logic        back_c;
  logic        cr_c;
  logic        lf_c;
  logic        home_c;
  logic [15:0] cell_addr_c;
  logic [15:0] bs_addr_c;

  function automatic logic [15:0] row_base(input logic [4:0] r);
    return BASE_ADDR + 16'(r) * 16'(COLS);
  endfunction

  assign accept_c    = I_char_valid && O_char_ready;
  assign printable_c = (I_char >= CHAR_SPACE) && (I_char <= 8'h7E);
  assign cell_addr_c = row_base(row) + 16'(col);
  assign bs_addr_c   = cell_addr_c - 16'd1;

  assign step_c = (state == WRITE) && !wr_bs;
  assign back_c = (state == WRITE) && wr_bs;
  assign cr_c   = accept_c && (I_char == CHAR_CR);
  assign lf_c   = accept_c && (I_char == CHAR_LF);
`ifdef CEESPU_CONSOLE_CLS_EN
  assign home_c = (state == CLEAR_SCREEN) && (clr_cnt == CLR_W'(SCREEN_WORDS));
`else
  assign home_c = 1'b0;
`endif

  ceespu_console_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk        (I_clk),
    .rst_n      (I_rst_n),
    .step       (step_c),
    .back       (back_c),
    .cr         (cr_c),
    .lf         (lf_c),
    .home       (home_c),
    .col        (col),
    .row        (row),
    .wrap_c     (wrap_c),
    .next_row_c (next_row_c)
  );

  assign O_cursor_col = col;
  assign O_cursor_row = row;

  // Control FSM; every write is registered so it appears the cycle after its cause.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state              <= IDLE;
      O_char_ready       <= 1'b0;
      O_sys_write_enable <= 4'b0000;
      O_sys_address      <= 16'h0000;
      O_sys_data         <= 32'h0000_0000;
      clr_cnt            <= '0;
      wr_bs              <= 1'b0;
    end else begin
      O_sys_write_enable <= 4'b0000;
      case (state)
        IDLE: begin
          O_char_ready <= 1'b1;
          if (accept_c) begin
            if (printable_c) begin
              state              <= WRITE;
              O_char_ready       <= 1'b0;
              wr_bs              <= 1'b0;
              O_sys_address      <= cell_addr_c;
              O_sys_data         <= {4{I_char}};
              O_sys_write_enable <= lane_strobe(cell_addr_c[1:0]);
            end else if ((I_char == CHAR_BS) && (col != 7'd0)) begin
              state              <= WRITE;
              O_char_ready       <= 1'b0;
              wr_bs              <= 1'b1;
              O_sys_address      <= bs_addr_c;
              O_sys_data         <= BLANK_WORD;
              O_sys_write_enable <= lane_strobe(bs_addr_c[1:0]);
            end else if (I_char == CHAR_LF) begin
              state              <= CLEAR_ROW;
              O_char_ready       <= 1'b0;
              O_sys_address      <= row_base(next_row_c);
              O_sys_data         <= BLANK_WORD;
              O_sys_write_enable <= 4'b1111;
              clr_cnt            <= CLR_W'(1);
            end
`ifdef CEESPU_CONSOLE_CLS_EN
            else if (I_char == CHAR_FF) begin
              state              <= CLEAR_SCREEN;
              O_char_ready       <= 1'b0;
              O_sys_address      <= BASE_ADDR;
              O_sys_data         <= BLANK_WORD;
              O_sys_write_enable <= 4'b1111;
              clr_cnt            <= CLR_W'(1);
            end
`endif
          end
        end

        WRITE: begin
          // A printable write in the last column wraps into a fresh, cleared line.
          if (!wr_bs && wrap_c) begin
            state              <= CLEAR_ROW;
            O_sys_address      <= row_base(next_row_c);
            O_sys_data         <= BLANK_WORD;
            O_sys_write_enable <= 4'b1111;
            clr_cnt            <= CLR_W'(1);
          end else begin
            state        <= IDLE;
            O_char_ready <= 1'b1;
          end
        end

        CLEAR_ROW: begin
          if (clr_cnt == CLR_W'(ROW_WORDS)) begin
            state        <= IDLE;
            O_char_ready <= 1'b1;
            clr_cnt      <= '0;
          end else begin
            O_sys_write_enable <= 4'b1111;
            O_sys_address      <= O_sys_address + 16'd4;
            clr_cnt            <= clr_cnt + CLR_W'(1);
          end
        end

`ifdef CEESPU_CONSOLE_CLS_EN
        CLEAR_SCREEN: begin
          if (clr_cnt == CLR_W'(SCREEN_WORDS)) begin
            state        <= IDLE;
            O_char_ready <= 1'b1;
            clr_cnt      <= '0;
          end else begin
            O_sys_write_enable <= 4'b1111;
            O_sys_address      <= O_sys_address + 16'd4;
            clr_cnt            <= clr_cnt + CLR_W'(1);
          end
        end
`endif

        default: begin
          state        <= IDLE;
          O_char_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
